// File: rtl/cache_pkg.sv
// Shared types and width helpers for the line write merger and its byte-merge datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READ    = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int bpw(input int word_width);
        return word_width / 8;
    endfunction

    function automatic int offset_width(input int word_width, input int word_count);
        return clog2(bpw(word_width) * word_count);
    endfunction

    function automatic int tag_width(input int addr_width, input int word_width,
                                     input int word_count);
        return addr_width - offset_width(word_width, word_count);
    endfunction

endpackage

// File: rtl/line_byte_merge.sv
// Byte-masked merge of one word into a line, also marking the written bytes valid.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
// Ports: line_in/mask_in (current line and per-byte valid), word/bval/word_idx (word to
//        merge, byte enables, target word slot), line_out/mask_out (merged result).
module line_byte_merge
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int WORD_COUNT = 4,
    parameter int IDX_W      = 2
) (
    input  logic [WORD_WIDTH*WORD_COUNT-1:0]       line_in,
    input  logic [(WORD_WIDTH/8)*WORD_COUNT-1:0]   mask_in,
    input  logic [WORD_WIDTH-1:0]                  word,
    input  logic [WORD_WIDTH/8-1:0]                bval,
    input  logic [IDX_W-1:0]                       word_idx,
    output logic [WORD_WIDTH*WORD_COUNT-1:0]       line_out,
    output logic [(WORD_WIDTH/8)*WORD_COUNT-1:0]   mask_out
);

    localparam int BPW = bpw(WORD_WIDTH);

    always_comb begin
        line_out = line_in;
        mask_out = mask_in;
        for (int w = 0; w < WORD_COUNT; w++) begin
            if (word_idx == IDX_W'(w)) begin
                for (int b = 0; b < BPW; b++) begin
                    if (bval[b]) begin
                        line_out[w*WORD_WIDTH + 8*b +: 8] = word[8*b +: 8];
                        mask_out[w*BPW + b]               = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/line_write_merger.sv
// Collects byte-masked stores to one cache line and writes the merged line back once.
// Latency: full line -> wb_valid 1 cycle after eviction trigger; partial -> rd_req 1 cycle
//          after trigger, wb_valid 1 cycle after rd_ack.
// Backpressure: wr_ready low outside IDLE/matching-COLLECT; rd_ack and wb_ready stall freely.
// Ports: wr_* store request (valid/ready), flush evicts the current line, busy = not IDLE,
//        rd_req/rd_addr/rd_ack/rd_line fetch of missing bytes, wb_* merged-line writeback.
module line_write_merger
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int WORD_COUNT = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            wr_valid,
    output logic                                            wr_ready,
    input  logic [ADDR_WIDTH-1:0]                           wr_addr,
    input  logic [WORD_WIDTH-1:0]                           wr_data,
    input  logic [WORD_WIDTH/8-1:0]                         wr_bval,
    input  logic                                            flush,
    output logic                                            busy,
    output logic                                            rd_req,
    output logic [tag_width(ADDR_WIDTH, WORD_WIDTH, WORD_COUNT)-1:0] rd_addr,
    input  logic                                            rd_ack,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0]                rd_line,
    output logic                                            wb_valid,
    input  logic                                            wb_ready,
    output logic [tag_width(ADDR_WIDTH, WORD_WIDTH, WORD_COUNT)-1:0] wb_addr,
    output logic [WORD_WIDTH*WORD_COUNT-1:0]                wb_line
);

    localparam int BPW          = bpw(WORD_WIDTH);
    localparam int LINE_BYTES   = BPW * WORD_COUNT;
    localparam int LINE_WIDTH   = WORD_WIDTH * WORD_COUNT;
    localparam int OFFSET_WIDTH = offset_width(WORD_WIDTH, WORD_COUNT);
    localparam int TAG_WIDTH    = tag_width(ADDR_WIDTH, WORD_WIDTH, WORD_COUNT);
    localparam int BOFF         = clog2(BPW);
    localparam int IDX_W        = (WORD_COUNT > 1) ? clog2(WORD_COUNT) : 1;
    localparam int TMR_W        = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [LINE_BYTES-1:0]   mask_q, mask_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [TAG_WIDTH-1:0]    rd_addr_d, wb_addr_d;
    logic [LINE_WIDTH-1:0]   wb_line_d;

    logic [TAG_WIDTH-1:0]    wr_tag;
    logic [IDX_W-1:0]        word_idx;
    logic                    tag_match;
    logic                    accept;
    logic [LINE_BYTES-1:0]   merge_mask_in;
    logic [LINE_WIDTH-1:0]   merge_line;
    logic [LINE_BYTES-1:0]   merge_mask;

    assign wr_tag    = wr_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign word_idx  = IDX_W'(wr_addr[OFFSET_WIDTH-1:0] >> BOFF);
    assign tag_match = (wr_tag == tag_q);

    // wr_ready is forced low during reset even though the state register already reads IDLE.
    always_comb begin
        wr_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE:    wr_ready = 1'b1;
                ST_COLLECT: wr_ready = tag_match;
                default:    wr_ready = 1'b0;
            endcase
        end
    end

    assign accept   = wr_valid & wr_ready;
    assign busy     = (state_q != ST_IDLE);
    assign rd_req   = (state_q == ST_READ);
    assign wb_valid = (state_q == ST_WRITE);

    // A new line starts from an empty mask; stale buffer bytes are ignored because their
    // mask bits are zero and they are replaced by fetched bytes before writeback.
    assign merge_mask_in = (state_q == ST_IDLE) ? '0 : mask_q;

    line_byte_merge #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT),
        .IDX_W      (IDX_W)
    ) u_store_merge (
        .line_in  (line_q),
        .mask_in  (merge_mask_in),
        .word     (wr_data),
        .bval     (wr_bval),
        .word_idx (word_idx),
        .line_out (merge_line),
        .mask_out (merge_mask)
    );

    // Fill path: each stage writes one word of rd_line into the bytes the buffer does not
    // yet own (inverted mask as byte enables), so buffered store data always wins.
    logic [LINE_WIDTH-1:0] fill_line [WORD_COUNT+1];
    logic [LINE_BYTES-1:0] fill_mask [WORD_COUNT+1];

    assign fill_line[0] = line_q;
    assign fill_mask[0] = mask_q;

    for (genvar w = 0; w < WORD_COUNT; w++) begin : g_fill
        line_byte_merge #(
            .WORD_WIDTH (WORD_WIDTH),
            .WORD_COUNT (WORD_COUNT),
            .IDX_W      (IDX_W)
        ) u_fill_merge (
            .line_in  (fill_line[w]),
            .mask_in  (fill_mask[w]),
            .word     (rd_line[w*WORD_WIDTH +: WORD_WIDTH]),
            .bval     (~fill_mask[w][w*BPW +: BPW]),
            .word_idx (IDX_W'(w)),
            .line_out (fill_line[w+1]),
            .mask_out (fill_mask[w+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        mask_d    = mask_q;
        line_d    = line_q;
        timer_d   = timer_q;
        rd_addr_d = rd_addr;
        wb_addr_d = wb_addr;
        wb_line_d = wb_line;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tag_d   = wr_tag;
                    mask_d  = merge_mask;
                    line_d  = merge_line;
                    timer_d = '0;
                    state_d = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (accept) begin
                    mask_d  = merge_mask;
                    line_d  = merge_line;
                    timer_d = '0;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                // The timeout compares the updated count, so the TIMEOUT-th consecutive idle
                // cycle is itself the trigger cycle. A same-cycle store is already in mask_d.
                if (flush || (wr_valid && !tag_match) || (timer_d == TMR_MAX)) begin
                    if (&mask_d) begin
                        wb_addr_d = tag_q;
                        wb_line_d = line_d;
                        state_d   = ST_WRITE;
                    end else begin
                        rd_addr_d = tag_q;
                        state_d   = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (rd_ack) begin
                    wb_addr_d = tag_q;
                    wb_line_d = fill_line[WORD_COUNT];
                    mask_d    = fill_mask[WORD_COUNT];
                    state_d   = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (wb_ready) begin
                    mask_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            mask_q  <= '0;
            line_q  <= '0;
            timer_q <= '0;
            rd_addr <= '0;
            wb_addr <= '0;
            wb_line <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            timer_q <= timer_d;
            rd_addr <= rd_addr_d;
            wb_addr <= wb_addr_d;
            wb_line <= wb_line_d;
        end
    end

endmodule

// File: tb/tb_line_write_merger.sv
// Directed bench for line_write_merger with default parameters (32-bit words, 4 words/line).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: rd_ack and wb_ready driven explicitly per step.
module tb_line_write_merger;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_bval;
    logic          flush;
    logic          busy;
    logic          rd_req;
    logic [27:0]   rd_addr;
    logic          rd_ack;
    logic [127:0]  rd_line;
    logic          wb_valid;
    logic          wb_ready;
    logic [27:0]   wb_addr;
    logic [127:0]  wb_line;

    int checks = 0;
    int passed = 0;

    line_write_merger #(
        .WORD_WIDTH (32),
        .WORD_COUNT (4),
        .ADDR_WIDTH (32),
        .TIMEOUT    (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_bval  (wr_bval),
        .flush    (flush),
        .busy     (busy),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_line  (rd_line),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_line  (wb_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted store: drive for one cycle, then drop wr_valid.
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bv);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        wr_bval  = bv;
        check("store_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        wr_bval  = 4'h0;
    endtask

    // Complete any pending fetch and writeback with zero fill, then confirm IDLE.
    task automatic drain(input string name);
        rd_line  = '0;
        rd_ack   = 1'b1;
        wb_ready = 1'b1;
        tick();
        tick();
        tick();
        rd_ack   = 1'b0;
        wb_ready = 1'b0;
        check(name, busy, 0);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_bval  = '0;
        flush    = 1'b0;
        rd_ack   = 1'b0;
        rd_line  = '0;
        wb_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_line", wb_line, 0);
        rst = 1'b0;
        #1;
        check("idle_wr_ready", wr_ready, 1);
        tick();

        // Full line: no fetch, writeback one cycle after flush
        store(32'h100, 32'hA0, 4'hF);
        store(32'h104, 32'hA1, 4'hF);
        store(32'h108, 32'hA2, 4'hF);
        store(32'h10C, 32'hA3, 4'hF);
        check("full_busy", busy, 1);
        flush = 1'b1;
        check("full_no_rdreq_pre", rd_req, 0);
        tick();
        flush = 1'b0;
        check("full_wb_valid", wb_valid, 1);
        check("full_no_rdreq", rd_req, 0);
        check("full_wb_addr", wb_addr, 28'h10);
        check("full_wb_line", wb_line, 128'h000000A3_000000A2_000000A1_000000A0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("full_idle", busy, 0);

        // Partial line: fetch fills the unwritten bytes
        store(32'h204, 32'hAABBCCDD, 4'b0101);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("part_rd_req", rd_req, 1);
        check("part_rd_addr", rd_addr, 28'h20);
        check("part_wr_ready", wr_ready, 0);
        tick();
        tick();
        tick();
        check("part_rd_req_held", rd_req, 1);
        rd_ack  = 1'b1;
        rd_line = {16{8'h11}};
        tick();
        rd_ack  = 1'b0;
        rd_line = '0;
        check("part_rd_req_drop", rd_req, 0);
        check("part_wb_valid", wb_valid, 1);
        check("part_wb_addr", wb_addr, 28'h20);
        check("part_wb_line", wb_line, 128'h11111111_11111111_11BB11DD_11111111);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("part_idle", busy, 0);

        // Tag conflict: a held store to another line forces eviction of the current one
        store(32'h300, 32'h33333333, 4'hF);
        wr_valid = 1'b1;
        wr_addr  = 32'h400;
        wr_data  = 32'h44444444;
        wr_bval  = 4'hF;
        #1;
        check("conf_ready_collect", wr_ready, 0);
        tick();
        check("conf_rd_req", rd_req, 1);
        check("conf_rd_addr", rd_addr, 28'h30);
        check("conf_ready_read", wr_ready, 0);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("conf_wb_valid", wb_valid, 1);
        check("conf_wb_addr", wb_addr, 28'h30);
        check("conf_wb_line", wb_line, 128'h00000000_00000000_00000000_33333333);
        check("conf_ready_write", wr_ready, 0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("conf_idle_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        check("conf_busy_after", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("conf_second_rd_addr", rd_addr, 28'h40);
        drain("conf_drain");

        // Timeout: rd_req 16 cycles after the accept cycle
        store(32'h500, 32'h55, 4'h1);
        repeat (14) tick();
        check("tmo_rd_req_c15", rd_req, 0);
        tick();
        check("tmo_rd_req_c16", rd_req, 1);
        drain("tmo_drain");

        // Timeout restarted by a matching store at cycle 10
        store(32'h500, 32'h55, 4'h1);
        repeat (9) tick();
        store(32'h508, 32'h66, 4'h0);
        repeat (14) tick();
        check("tmo2_rd_req_c25", rd_req, 0);
        tick();
        check("tmo2_rd_req_c26", rd_req, 1);
        drain("tmo2_drain");

        // Overlapping stores (later wins) and writeback backpressure
        store(32'h600, 32'hAA, 4'b0001);
        store(32'h600, 32'hBB, 4'b0001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ovl_rd_req", rd_req, 1);
        rd_ack  = 1'b1;
        rd_line = {16{8'h22}};
        tick();
        rd_ack  = 1'b0;
        rd_line = {16{8'h99}};
        for (int i = 0; i < 5; i++) begin
            check("ovl_stall_valid", wb_valid, 1);
            check("ovl_stall_line", wb_line, 128'h22222222_22222222_22222222_222222BB);
            tick();
        end
        check("ovl_stall_addr", wb_addr, 28'h60);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("ovl_idle", busy, 0);

        // Reset during READ discards the line immediately
        store(32'h800, 32'h77, 4'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("rstrd_rd_req_pre", rd_req, 1);
        rst = 1'b1;
        #1;
        check("rstrd_rd_req", rd_req, 0);
        check("rstrd_rd_addr", rd_addr, 0);
        check("rstrd_busy", busy, 0);
        check("rstrd_wr_ready", wr_ready, 0);
        check("rstrd_wb_valid", wb_valid, 0);
        check("rstrd_wb_addr", wb_addr, 0);
        check("rstrd_wb_line", wb_line, 0);
        tick();
        rst = 1'b0;
        tick();
        store(32'h700, 32'h12345678, 4'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("post_rd_req", rd_req, 1);
        check("post_rd_addr", rd_addr, 28'h70);
        rd_ack  = 1'b1;
        rd_line = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        tick();
        rd_ack  = 1'b0;
        check("post_wb_addr", wb_addr, 28'h70);
        check("post_wb_line", wb_line, 128'hFFEEDDCC_BBAA9988_77665544_33221178);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("post_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
